// File: rtl/ctrl_pkg.sv
// ctrl_pkg: opcodes, ALU function encodings and FSM states shared by the control unit
package ctrl_pkg;
  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_MOV   = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_AND   = 8'h04;
  localparam logic [7:0] OP_OR    = 8'h05;
  typedef enum logic [2:0] {
    ALU_FWD = 3'b000,
    ALU_ADD = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011
  } aluop_t;
  typedef enum logic [1:0] {IDLE, EXEC, WB, ERR} state_t;
endpackage

// File: rtl/instr_decoder.sv
// instr_decoder: combinational opcode to ALU control mapping
module instr_decoder
  import ctrl_pkg::*;
(
  input  logic [7:0] opcode,
  output aluop_t     aluop,
  output logic       imm_sel,
  output logic       neg_sel,
  output logic       legal
);
  always_comb begin
    legal = opcode <= OP_OR;
    imm_sel = opcode == OP_LOADI;
    neg_sel = opcode == OP_SUB;
    aluop = (opcode == OP_ADD || opcode == OP_SUB) ? ALU_ADD :
            opcode == OP_AND ? ALU_AND :
            opcode == OP_OR  ? ALU_OR  : ALU_FWD;
  end
endmodule

// File: rtl/control_unit.sv
// control_unit: accepts one instruction at a time, registers its decoded controls
// and sequences EXEC (1 or 2 cycles) -> WB write strobe, or ERR for illegal opcodes
module control_unit
  import ctrl_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] INSTRUCTION,
  input  logic        INSTR_VALID,
  output logic        INSTR_READY,
  output logic [2:0]  ALUOP,
  output logic        IMM_SEL,
  output logic        NEG_SEL,
  output logic [2:0]  READREG1,
  output logic [2:0]  READREG2,
  output logic [2:0]  WRITEREG,
  output logic [7:0]  IMMEDIATE,
  output logic        WRITEENABLE,
  output logic        ILLEGAL
);
  state_t state, next;
  aluop_t aluop_d;
  logic   imm_sel_d, neg_sel_d, legal, cnt, accept;
  logic   unused_bits;
  assign unused_bits = ^{INSTRUCTION[23:19], INSTRUCTION[15:11]};
  assign accept = INSTR_VALID && state == IDLE;
  instr_decoder u_dec (
    .opcode  (INSTRUCTION[31:24]),
    .aluop   (aluop_d),
    .imm_sel (imm_sel_d),
    .neg_sel (neg_sel_d),
    .legal   (legal)
  );
  // cnt set on accept means the adder needs one extra EXEC cycle
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state     <= IDLE;
      cnt       <= 1'b0;
      ALUOP     <= '0;
      IMM_SEL   <= 1'b0;
      NEG_SEL   <= 1'b0;
      READREG1  <= '0;
      READREG2  <= '0;
      WRITEREG  <= '0;
      IMMEDIATE <= '0;
    end else begin
      state <= next;
      if (accept) begin
        cnt       <= aluop_d == ALU_ADD;
        ALUOP     <= aluop_d;
        IMM_SEL   <= imm_sel_d;
        NEG_SEL   <= neg_sel_d;
        READREG1  <= INSTRUCTION[10:8];
        READREG2  <= INSTRUCTION[2:0];
        WRITEREG  <= INSTRUCTION[18:16];
        IMMEDIATE <= INSTRUCTION[7:0];
      end else if (state == EXEC) begin
        cnt <= 1'b0;
      end
    end
  end
  always_comb begin
    next = state == IDLE ? (accept ? (legal ? EXEC : ERR) : IDLE) :
           state == EXEC ? (cnt ? EXEC : WB) : IDLE;
  end
  always_comb begin
    INSTR_READY = state == IDLE;
    WRITEENABLE = state == WB;
    ILLEGAL     = state == ERR;
  end
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: table-driven directed vectors plus reset, back-pressure and reset-abort sequences
module tb_control_unit;
  logic        CLK = 1'b0, RESET = 1'b0, INSTR_VALID = 1'b0;
  logic [31:0] INSTRUCTION = '0;
  logic        INSTR_READY, IMM_SEL, NEG_SEL, WRITEENABLE, ILLEGAL;
  logic [2:0]  ALUOP, READREG1, READREG2, WRITEREG;
  logic [7:0]  IMMEDIATE;
  logic [24:0] outs;
  int checks = 0, errors = 0;
  localparam logic [24:0] RST_OUTS = 25'h100_0000;
  control_unit dut (
    .CLK(CLK), .RESET(RESET), .INSTRUCTION(INSTRUCTION), .INSTR_VALID(INSTR_VALID),
    .INSTR_READY(INSTR_READY), .ALUOP(ALUOP), .IMM_SEL(IMM_SEL), .NEG_SEL(NEG_SEL),
    .READREG1(READREG1), .READREG2(READREG2), .WRITEREG(WRITEREG),
    .IMMEDIATE(IMMEDIATE), .WRITEENABLE(WRITEENABLE), .ILLEGAL(ILLEGAL)
  );
  assign outs = {INSTR_READY, ALUOP, IMM_SEL, NEG_SEL, READREG1, READREG2, WRITEREG,
                 IMMEDIATE, WRITEENABLE, ILLEGAL};
  always #5 CLK = ~CLK;
  typedef struct {
    logic [31:0] instr;
    logic [2:0]  aluop;
    logic        imm_sel;
    logic        neg_sel;
    logic [2:0]  rr1;
    logic [2:0]  rr2;
    logic [2:0]  wr;
    logic [7:0]  imm;
    int          lat;
    int          we_at;
    logic        ill;
  } vec_t;
  vec_t vecs[9];
  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask
  // accept v, then watch strobes cycle by cycle until READY returns (bounded)
  task automatic run(input vec_t v, input int idx);
    int lat, we_n, we_at, ill_n;
    lat = 0; we_n = 0; we_at = 0; ill_n = 0;
    @(negedge CLK);
    chk($sformatf("v%0d ready_before", idx), int'(INSTR_READY), 1);
    INSTR_VALID = 1'b1;
    INSTRUCTION = v.instr;
    @(posedge CLK);
    #1;
    INSTR_VALID = 1'b0;
    INSTRUCTION = $urandom;
    for (int k = 1; k <= 8; k++) begin
      @(negedge CLK);
      if (WRITEENABLE) begin we_n++; we_at = k; end
      if (ILLEGAL) ill_n++;
      if (INSTR_READY) begin lat = k; break; end
    end
    chk($sformatf("v%0d latency", idx), lat, v.lat);
    chk($sformatf("v%0d we_count", idx), we_n, v.ill ? 0 : 1);
    chk($sformatf("v%0d we_cycle", idx), we_at, v.we_at);
    chk($sformatf("v%0d illegal_count", idx), ill_n, v.ill ? 1 : 0);
    if (!v.ill) begin
      chk($sformatf("v%0d aluop", idx), int'(ALUOP), int'(v.aluop));
      chk($sformatf("v%0d imm_sel", idx), int'(IMM_SEL), int'(v.imm_sel));
      chk($sformatf("v%0d neg_sel", idx), int'(NEG_SEL), int'(v.neg_sel));
      chk($sformatf("v%0d readreg1", idx), int'(READREG1), int'(v.rr1));
      chk($sformatf("v%0d readreg2", idx), int'(READREG2), int'(v.rr2));
      chk($sformatf("v%0d writereg", idx), int'(WRITEREG), int'(v.wr));
      chk($sformatf("v%0d immediate", idx), int'(IMMEDIATE), int'(v.imm));
    end
  endtask
  initial begin
    int seen_we, seen_ill;
    vecs[0] = '{32'h0002_00AB, 3'd0, 1'b1, 1'b0, 3'd0, 3'd3, 3'd2, 8'hAB, 3, 2, 1'b0};
    vecs[1] = '{32'h0304_0201, 3'd1, 1'b0, 1'b1, 3'd2, 3'd1, 3'd4, 8'h01, 4, 3, 1'b0};
    vecs[2] = '{32'h0700_0000, 3'd0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 8'h00, 2, 0, 1'b1};
    vecs[3] = '{32'h02FD_F8FE, 3'd1, 1'b0, 1'b0, 3'd0, 3'd6, 3'd5, 8'hFE, 4, 3, 1'b0};
    vecs[4] = '{32'h0101_0305, 3'd0, 1'b0, 1'b0, 3'd3, 3'd5, 3'd1, 8'h05, 3, 2, 1'b0};
    vecs[5] = '{32'h0407_0706, 3'd2, 1'b0, 1'b0, 3'd7, 3'd6, 3'd7, 8'h06, 3, 2, 1'b0};
    vecs[6] = '{32'h0500_0107, 3'd3, 1'b0, 1'b0, 3'd1, 3'd7, 3'd0, 8'h07, 3, 2, 1'b0};
    vecs[7] = '{32'h0612_3456, 3'd0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 8'h00, 2, 0, 1'b1};
    vecs[8] = '{32'hFF00_0000, 3'd0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 8'h00, 2, 0, 1'b1};
    // reset held for 3 cycles
    INSTR_VALID = 1'b1;
    INSTRUCTION = 32'h0304_0201;
    repeat (3) @(negedge CLK);
    chk("reset_held_outputs", int'(outs), int'(RST_OUTS));
    INSTR_VALID = 1'b0;
    RESET = 1'b1;
    @(negedge CLK);
    chk("reset_release_outputs", int'(outs), int'(RST_OUTS));
    for (int i = 0; i < 9; i++) run(vecs[i], i);
    // back-pressure: VALID stays high across two different instructions
    @(negedge CLK);
    INSTR_VALID = 1'b1;
    INSTRUCTION = 32'h0101_0305;
    @(negedge CLK);
    INSTRUCTION = 32'h0407_0706;
    chk("bp_k1_writereg", int'(WRITEREG), 1);
    chk("bp_k1_ready", int'(INSTR_READY), 0);
    @(negedge CLK);
    chk("bp_k2_we", int'(WRITEENABLE), 1);
    chk("bp_k2_aluop", int'(ALUOP), 0);
    @(negedge CLK);
    chk("bp_k3_ready", int'(INSTR_READY), 1);
    chk("bp_k3_writereg", int'(WRITEREG), 1);
    @(negedge CLK);
    INSTR_VALID = 1'b0;
    chk("bp_k4_ready", int'(INSTR_READY), 0);
    chk("bp_k4_writereg", int'(WRITEREG), 7);
    chk("bp_k4_aluop", int'(ALUOP), 2);
    repeat (3) @(negedge CLK);
    chk("bp_done_ready", int'(INSTR_READY), 1);
    // reset asserted during EXEC of an add
    @(negedge CLK);
    INSTR_VALID = 1'b1;
    INSTRUCTION = 32'h0203_0201;
    @(negedge CLK);
    INSTR_VALID = 1'b0;
    chk("abort_in_exec", int'(INSTR_READY), 0);
    chk("abort_pre_writereg", int'(WRITEREG), 3);
    #2 RESET = 1'b0;
    #1 chk("abort_async_outputs", int'(outs), int'(RST_OUTS));
    @(negedge CLK);
    RESET = 1'b1;
    seen_we = 0; seen_ill = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      if (WRITEENABLE) seen_we++;
      if (ILLEGAL) seen_ill++;
    end
    chk("abort_no_we", seen_we, 0);
    chk("abort_no_illegal", seen_ill, 0);
    chk("abort_ready", int'(INSTR_READY), 1);
    run(vecs[3], 9);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; CLK is the sole clock and RESET is the reset port name, asserted low.
REQ-002 CLK  input  1  rising-edge clock for all state.
REQ-003 RESET  input  1  asynchronous active-low reset.
REQ-004 INSTRUCTION  input  32  instruction word: [31:24] opcode, [18:16] destination, [10:8] source1, [7:0] source2 (bits [2:0]) or immediate.
REQ-005 INSTR_VALID  input  1  INSTRUCTION holds a valid instruction.
REQ-006 INSTR_READY  output  1  block can accept an instruction this cycle.
REQ-007 ALUOP  output  3  ALU function select: 000 forward, 001 add, 010 and, 011 or.
REQ-008 IMM_SEL  output  1  ALU DATA2 is taken from IMMEDIATE instead of register source2.
REQ-009 NEG_SEL  output  1  ALU DATA2 is two's-complemented before the ALU.
REQ-010 READREG1, READREG2, WRITEREG  output  3 each  register-file read and write addresses.
REQ-011 IMMEDIATE  output  8  immediate field INSTRUCTION[7:0].
REQ-012 WRITEENABLE  output  1  register-file write strobe, one cycle per legal instruction.
REQ-013 ILLEGAL  output  1  one-cycle pulse marking an unsupported opcode.

Function
REQ-014 Opcodes SHALL be: loadi 0x00 (ALUOP 000, IMM_SEL 1), mov 0x01 (000), add 0x02 (001), sub 0x03 (001, NEG_SEL 1), and 0x04 (010), or 0x05 (011); all others are illegal.
REQ-015 The FSM SHALL have states IDLE, EXEC, WB and ERR; INSTR_READY SHALL be 1 only in IDLE.
REQ-016 An instruction SHALL be accepted only on a rising edge where INSTR_VALID=1 and INSTR_READY=1; INSTR_VALID while not ready SHALL be ignored, with no queueing.
REQ-017 On the accepting edge all control outputs SHALL be registered from the decoded instruction, and the FSM SHALL go to EXEC if legal, or ERR if illegal.
REQ-018 EXEC SHALL last 2 cycles for add and sub, matching the 2-unit adder delay, and 1 cycle for all other legal opcodes; a 1-bit cycle counter tracks this.
REQ-019 EXEC SHALL go to WB; in WB, WRITEENABLE SHALL be 1 for exactly one cycle; WB SHALL then go to IDLE.
REQ-020 ERR SHALL last one cycle with ILLEGAL=1 and WRITEENABLE=0, then return to IDLE; decoded outputs are don't-care while in ERR.
REQ-021 Latency from accept edge T to return to IDLE (INSTR_READY=1) SHALL be T+3 cycles for 1-cycle operations, T+4 for add/sub and T+2 for illegal opcodes.
REQ-022 ALUOP, IMM_SEL, NEG_SEL, READREG1, READREG2, WRITEREG and IMMEDIATE SHALL hold stable from the accept edge until the next accept edge.
REQ-023 INSTRUCTION bits outside the defined fields SHALL be ignored.
REQ-024 An instruction accepted on the edge where the FSM enters IDLE SHALL NOT be possible; acceptance requires INSTR_READY to have been 1 during the preceding cycle.

Reset
REQ-025 While RESET=0, the FSM SHALL be in IDLE with INSTR_READY=1, and all other outputs SHALL be 0.
REQ-026 Assertion of RESET mid-instruction SHALL abort the instruction immediately; no WRITEENABLE or ILLEGAL pulse SHALL follow after release.

Structure
REQ-027 A shared package ctrl_pkg SHALL hold the opcode constants, the ALUOP encodings and the FSM state enumeration.
REQ-028 Opcode-to-control mapping SHALL live in one combinational sub-module, instr_decoder, producing ALUOP, IMM_SEL, NEG_SEL and legal.

Verification
REQ-029 Reset scenario: hold RESET=0 for 3 cycles and release -> INSTR_READY=1, with all other outputs 0.
REQ-030 Load-immediate scenario: accept loadi with INSTRUCTION=0x0002_00AB -> ALUOP=000, IMM_SEL=1, IMMEDIATE=0xAB, WRITEREG=2, WRITEENABLE high in cycle T+2 only, INSTR_READY=1 at T+3.
REQ-031 Subtract scenario: accept sub with INSTRUCTION=0x0304_0201 -> ALUOP=001, NEG_SEL=1, READREG1=2, READREG2=1, WRITEREG=4, WRITEENABLE high at T+3, INSTR_READY=1 at T+4.
REQ-032 Illegal-opcode scenario: accept opcode 0x07 -> ILLEGAL=1 for one cycle, WRITEENABLE never 1, INSTR_READY=1 at T+2.
REQ-033 Back-pressure scenario: hold INSTR_VALID high continuously with two different instructions -> the second is accepted only at T+3 and its outputs do not disturb the first.
REQ-034 Reset-abort scenario: assert RESET during EXEC of an add -> outputs drop to reset values asynchronously, and no WRITEENABLE pulse follows release.
